// File: rtl/sme_dom_logic.sv
// Masked bitwise logic unit (AND / OR / ANDN / XOR) on D-share Boolean-masked
// operands using domain-oriented masking. The pipeline has two stages with
// valid/ready flow control. Each accepted operation consumes one fresh randomness
// word set.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no stage occupied
// ST_ONE   | exactly one of stage 1 / output occupied
// ST_TWO   | stage 1 and output both occupied
module sme_dom_logic #(
    parameter int D = 3,
    parameter int N = 32,
    localparam int RW = N * D * (D - 1) / 2
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [D*N-1:0]    rs1,
    input  logic [D*N-1:0]    rs2,
    input  logic              rng_valid,
    output logic              rng_ready,
    input  logic [RW-1:0]     rng,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [D*N-1:0]    rd,
    output logic              busy
);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_ANDN = 2'b10,
        OP_XOR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 out_valid_q, out_valid_d;
    op_e                  op1_q;
    logic [D*D*N-1:0]     term_q, term_d;
    logic [D*N-1:0]       rd_q, rd_d;
    logic [D*N-1:0]       x, y;
    logic                 adv1, adv2, accept;

    assign adv2      = !out_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign in_ready  = rng_valid && adv1 && !flush;
    assign rng_ready = in_valid && in_ready;
    assign accept    = rng_ready;

    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign busy      = (state_q != ST_EMPTY);

    // Map OR and ANDN onto AND by inverting share 0 of the relevant operands
    always_comb begin
        x = rs1;
        y = rs2;
        if (op == OP_OR) begin
            x[N-1:0] = ~rs1[N-1:0];
        end
        if (op == OP_OR || op == OP_ANDN) begin
            y[N-1:0] = ~rs2[N-1:0];
        end
    end

    // Cross-domain terms. Each unordered share pair shares a single random word.
    // XOR places only that word in the cross terms, so XOR has the same timing
    // and the same randomness usage as the other operations.
    for (genvar gs = 0; gs < D; gs++) begin : g_share
        for (genvar gp = 0; gp < D; gp++) begin : g_term
            if (gs == gp) begin : g_inner
                assign term_d[(gs*D+gp)*N +: N] = (op == OP_XOR)
                    ? (x[gs*N +: N] ^ y[gp*N +: N])
                    : (x[gs*N +: N] & y[gp*N +: N]);
            end else begin : g_cross
                localparam int LO = (gs < gp) ? gs : gp;
                localparam int HI = (gs < gp) ? gp : gs;
                localparam int K  = LO + HI * (HI - 1) / 2;
                assign term_d[(gs*D+gp)*N +: N] = (op == OP_XOR)
                    ? rng[K*N +: N]
                    : ((x[gs*N +: N] & y[gp*N +: N]) ^ rng[K*N +: N]);
            end
        end
    end

    // Fold the registered terms of each domain into its output share
    always_comb begin
        rd_d = '0;
        for (int s = 0; s < D; s++) begin
            for (int p = 0; p < D; p++) begin
                rd_d[s*N +: N] = rd_d[s*N +: N] ^ term_q[(s*D+p)*N +: N];
            end
        end
        if (op1_q == OP_OR) begin
            rd_d[N-1:0] = ~rd_d[N-1:0];
        end
    end

    // Next stage-valid bits and occupancy state. Flush overrides any advance.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        state_d     = state_q;
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (adv2) out_valid_d = s1_valid_q;
            if (adv1) s1_valid_d  = accept;
        end
        case ({s1_valid_d, out_valid_d})
            2'b00:   state_d = ST_EMPTY;
            2'b11:   state_d = ST_TWO;
            default: state_d = ST_ONE;
        endcase
    end

    // Control registers
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q     <= ST_EMPTY;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Stage-1 term and op registers. These load only on accept; a flush leaves them holding their values.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            term_q <= '0;
            op1_q  <= OP_AND;
        end else if (accept) begin
            term_q <= term_d;
            op1_q  <= op_e'(op);
        end
    end

    // Output share register. It is stable while the result is held under back-pressure.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            rd_q <= '0;
        end else if (!flush && adv2 && s1_valid_q) begin
            rd_q <= rd_d;
        end
    end

endmodule

// File: tb/tb_sme_dom_logic.sv
// Directed bench for sme_dom_logic. The bench pushes expected unmasked results
// into a queue when it drives an operation. A negedge monitor pops one entry and
// compares it for every result handshake.
module tb_sme_dom_logic;

    localparam int D  = 3;
    localparam int N  = 8;
    localparam int RW = N * D * (D - 1) / 2;

    logic              g_clk, g_reset, flush;
    logic              in_valid, in_ready;
    logic [1:0]        op;
    logic [D*N-1:0]    rs1, rs2, rd;
    logic              rng_valid, rng_ready;
    logic [RW-1:0]     rng;
    logic              out_valid, out_ready, busy;

    int                checks = 0;
    int                errors = 0;
    logic [N-1:0]      sb[$];
    logic [N-1:0]      mon_exp;
    logic [D*N-1:0]    hold, rd_a, rd_b;

    localparam logic [D*N-1:0] A  = 24'h55330F;  // unmasked 0x69
    localparam logic [D*N-1:0] B  = 24'h0F00FF;  // unmasked 0xF0
    localparam logic [D*N-1:0] C  = 24'hA1B2C3;  // unmasked 0xD0
    localparam logic [D*N-1:0] E  = 24'h123456;  // unmasked 0x70

    sme_dom_logic #(.D(D), .N(N)) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .rng_valid (rng_valid),
        .rng_ready (rng_ready),
        .rng       (rng),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .busy      (busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] unmask(input logic [D*N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) r = r ^ v[i*N +: N];
        return r;
    endfunction

    function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a & ~b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Drive one operation and wait (bounded) for its accept. Returns just after the accepting edge.
    task automatic drive_op(input logic [1:0] o, input logic [D*N-1:0] a,
                            input logic [D*N-1:0] b, input logic [RW-1:0] r, input bit push);
        int n;
        op = o; rs1 = a; rs2 = b; rng = r;
        in_valid = 1'b1; rng_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge g_clk);
            #2;
            n++;
        end
        chk("accept_rng_ready", rng_ready, 1);
        if (push && rng_ready) sb.push_back(model(o, unmask(a), unmask(b)));
        @(posedge g_clk);
        #1;
        in_valid = 1'b0; rng_valid = 1'b0;
    endtask

    // Two-cycle latency with out_ready=1, starting just after the accepting edge
    task automatic lat_check(input string tag);
        chk({tag, "_c1_out_valid"}, out_valid, 0);
        chk({tag, "_c1_busy"}, busy, 1);
        tick();
        chk({tag, "_c2_out_valid"}, out_valid, 1);
        tick();
        chk({tag, "_drained_busy"}, busy, 0);
    endtask

    // Scoreboard monitor: compare the unmasked result at each output handshake
    always @(negedge g_clk) begin
        if (!g_reset && out_valid && out_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_result: observed=%0h expected=none", unmask(rd));
            end
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                chk("result", unmask(rd), mon_exp);
            end
        end
    end

    initial begin
        g_reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 2'b00;
        rs1 = '0; rs2 = '0; rng_valid = 1'b0; rng = '0; out_ready = 1'b0;

        // reset state
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd", rd, 0);
        chk("rst_rng_ready", rng_ready, 0);
        g_reset = 1'b0;
        out_ready = 1'b1;
        tick();

        // all four ops, identical latency
        drive_op(2'b00, A, B, RW'($urandom), 1'b1); lat_check("and");
        drive_op(2'b01, A, B, RW'($urandom), 1'b1); lat_check("or");
        drive_op(2'b10, A, B, RW'($urandom), 1'b1); lat_check("andn");
        drive_op(2'b11, A, B, RW'($urandom), 1'b1); lat_check("xor");

        // mask independence: exact shares for two randomness words
        drive_op(2'b00, A, B, 24'h000000, 1'b1);
        tick(); rd_a = rd; tick();
        drive_op(2'b00, A, B, 24'h5A3C96, 1'b1);
        tick(); rd_b = rd; tick();
        chk("shares_r0", rd_a, 24'h503000);
        chk("shares_r1", rd_b, 24'h36FCAA);
        checks++;
        assert (rd_a !== rd_b) else begin
            errors++;
            $error("FAIL shares_differ: observed=%0h expected!=%0h", rd_b, rd_a);
        end

        // back-pressure: third op stalls, rd holds, then in-order drain
        out_ready = 1'b0;
        drive_op(2'b11, A, B, RW'($urandom), 1'b1);
        drive_op(2'b01, C, E, RW'($urandom), 1'b1);
        op = 2'b10; rs1 = A; rs2 = B; rng = RW'($urandom);
        in_valid = 1'b1; rng_valid = 1'b1;
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_rng_ready", rng_ready, 0);
        chk("bp_busy", busy, 1);
        hold = rd;
        repeat (3) tick();
        chk("bp_rd_stable", rd, hold);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rng_ready", rng_ready, 1);
        if (rng_ready) sb.push_back(model(2'b10, unmask(A), unmask(B)));
        tick();
        in_valid = 1'b0; rng_valid = 1'b0;
        repeat (4) tick();
        chk("bp_drained_busy", busy, 0);

        // randomness not available: no accept until rng_valid
        op = 2'b00; rs1 = C; rs2 = E; rng = RW'($urandom);
        in_valid = 1'b1; rng_valid = 1'b0;
        #1;
        chk("norng_in_ready", in_ready, 0);
        chk("norng_rng_ready", rng_ready, 0);
        tick(); tick();
        chk("norng_busy", busy, 0);
        rng_valid = 1'b1;
        #1;
        chk("rng_in_ready", in_ready, 1);
        chk("rng_rng_ready", rng_ready, 1);
        if (rng_ready) sb.push_back(model(2'b00, unmask(C), unmask(E)));
        tick();
        in_valid = 1'b0; rng_valid = 1'b0;
        repeat (3) tick();
        chk("rng_drained_busy", busy, 0);

        // flush from the two-occupied state: data kept, valids cleared
        out_ready = 1'b0;
        drive_op(2'b00, A, B, RW'($urandom), 1'b0);
        drive_op(2'b01, A, B, RW'($urandom), 1'b0);
        chk("pre_flush_busy", busy, 1);
        hold = rd;
        in_valid = 1'b1; rng_valid = 1'b1; flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_rng_ready", rng_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; rng_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_rd_kept", rd, hold);
        out_ready = 1'b1;
        drive_op(2'b11, C, E, RW'($urandom), 1'b1);
        lat_check("post_flush");

        // async reset mid-operation, checked before any clock edge
        out_ready = 1'b0;
        drive_op(2'b10, C, E, RW'($urandom), 1'b0);
        tick();
        chk("prerst_out_valid", out_valid, 1);
        #2;
        g_reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rd", rd, 0);
        tick();
        g_reset = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
